// File: rtl/adc_ad7476_pkg.sv
// Shared types and constants for the AD7476 capture front end.
package adc_ad7476_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_QUIET = 3'd4
  } adc_state_t;

  // PUSH_FLAG code the FIFO reports when it has no room.
  localparam logic [3:0] FIFO_FULL_FLAG = 4'h0;

  // The AD7476 frame: four leading zeros followed by the 12-bit result.
  localparam int ADC_FRAME_BITS = 16;

endpackage

// File: rtl/adc_sample_timer.sv
// Conversion pacing: a free-running period counter gated by Enable.
// tick is asserted on the first cycle of each period.
module adc_sample_timer
  import adc_ad7476_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CW-1:0] cnt;

  // Count 0..SAMPLE_PERIOD-1 while enabled; park at 0 when disabled so the
  // first tick after Enable rises is immediate.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == CW'(SAMPLE_PERIOD - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/adc_ad7476_capture.sv
// AD7476 serial capture: paces conversions, drives CS_n/SCLK, shifts in the
// 16-bit frame and pushes it into the downstream sample FIFO.
//
// state | meaning
// IDLE  | waiting for a sample tick, CS_n high, SCLK high
// SETUP | CS_n low, SCLK high for SCLK_DIV cycles before the first fall
// SHIFT | 16 SCLK periods; SDATA captured at the end of each low phase
// DONE  | one cycle: CS_n high, word presented, push or flag overflow
// QUIET | CS_n held high for CS_QUIET cycles before the next frame
module adc_ad7476_capture
  import adc_ad7476_pkg::*;
#(
  parameter int SCLK_DIV      = 2,
  parameter int CS_QUIET      = 4,
  parameter int SAMPLE_PERIOD = 80
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic        Ovf_Clr,
  input  logic        SDATA,
  input  logic [3:0]  Push_Flag,
  output logic        CS_n,
  output logic        SCLK,
  output logic        Fifo_Push,
  output logic [15:0] Fifo_Din,
  output logic        Busy,
  output logic        Overflow,
  output logic        Frame_Err
);

  localparam int DLY_MAX = (SCLK_DIV > CS_QUIET) ? SCLK_DIV : CS_QUIET;
  localparam int DW      = $clog2(DLY_MAX + 1);

  adc_state_t                state;
  logic [DW-1:0]             dly_cnt;
  logic [3:0]                bit_cnt;
  logic [ADC_FRAME_BITS-1:0] shift_reg;
  logic                      tick;

  adc_sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (Clk),
    .rst   (Rst),
    .enable(Enable),
    .tick  (tick)
  );

  // Push_Flag is only meaningful in the DONE cycle, and the FIFO takes the
  // push on that same edge, so the strobe is qualified combinationally from
  // the registered state.
  assign Fifo_Push = (state == ST_DONE) && (Push_Flag != FIFO_FULL_FLAG);
  assign Busy      = (state != ST_IDLE);

  // Frame sequencer: state, SCLK phase down-counter, bit counter, shift
  // register, registered pin outputs and the sticky status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      dly_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      CS_n      <= 1'b1;
      SCLK      <= 1'b1;
      Fifo_Din  <= '0;
      Overflow  <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      // Clear first so that a set in DONE on the same edge takes priority.
      if (Ovf_Clr) begin
        Overflow  <= 1'b0;
        Frame_Err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (tick) begin
            state   <= ST_SETUP;
            CS_n    <= 1'b0;
            SCLK    <= 1'b1;
            dly_cnt <= DW'(SCLK_DIV - 1);
          end
        end

        ST_SETUP: begin
          if (dly_cnt == '0) begin
            state   <= ST_SHIFT;
            SCLK    <= 1'b0;
            dly_cnt <= DW'(SCLK_DIV - 1);
            bit_cnt <= 4'(ADC_FRAME_BITS - 1);
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
          end else if (!SCLK) begin
            // End of low phase: this edge raises SCLK, so capture now.
            shift_reg <= {shift_reg[ADC_FRAME_BITS-2:0], SDATA};
            SCLK      <= 1'b1;
            dly_cnt   <= DW'(SCLK_DIV - 1);
          end else if (bit_cnt == '0) begin
            state    <= ST_DONE;
            CS_n     <= 1'b1;
            Fifo_Din <= shift_reg;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            SCLK    <= 1'b0;
            dly_cnt <= DW'(SCLK_DIV - 1);
          end
        end

        ST_DONE: begin
          if (Push_Flag == FIFO_FULL_FLAG) begin
            Overflow <= 1'b1;
          end
          if (shift_reg[ADC_FRAME_BITS-1 -: 4] != 4'h0) begin
            Frame_Err <= 1'b1;
          end
          state   <= ST_QUIET;
          dly_cnt <= DW'(CS_QUIET - 1);
        end

        ST_QUIET: begin
          if (dly_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          CS_n  <= 1'b1;
          SCLK  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ad7476_capture.sv
// Directed bench for adc_ad7476_capture with a behavioural AD7476 model.
module tb_adc_ad7476_capture;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Enable = 1'b0;
  logic        Ovf_Clr = 1'b0;
  logic        SDATA = 1'b0;
  logic [3:0]  Push_Flag = 4'hF;
  logic        CS_n;
  logic        SCLK;
  logic        Fifo_Push;
  logic [15:0] Fifo_Din;
  logic        Busy;
  logic        Overflow;
  logic        Frame_Err;

  always #5 Clk = ~Clk;

  adc_ad7476_capture dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Enable   (Enable),
    .Ovf_Clr  (Ovf_Clr),
    .SDATA    (SDATA),
    .Push_Flag(Push_Flag),
    .CS_n     (CS_n),
    .SCLK     (SCLK),
    .Fifo_Push(Fifo_Push),
    .Fifo_Din (Fifo_Din),
    .Busy     (Busy),
    .Overflow (Overflow),
    .Frame_Err(Frame_Err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // ADC model: loads a word on CS_n falling, advances one bit per SCLK rise.
  logic [15:0] adc_word = 16'h0000;
  logic        adc_inc = 1'b0;
  int          inc_base = 0;
  int          m_frames = 0;
  logic [15:0] cur_word = 16'h0000;
  logic [4:0]  bit_idx = 5'd0;
  logic        m_prev_cs = 1'b1;
  logic        m_prev_sclk = 1'b1;

  always @(negedge Clk) begin
    if (CS_n) begin
      bit_idx = 5'd0;
    end else if (m_prev_cs) begin
      bit_idx  = 5'd0;
      cur_word = adc_inc ? adc_word + 16'(m_frames - inc_base) : adc_word;
      m_frames++;
    end else if (SCLK && !m_prev_sclk) begin
      bit_idx++;
    end
    m_prev_cs   = CS_n;
    m_prev_sclk = SCLK;
    SDATA = (!CS_n && bit_idx < 5'd16) ? cur_word[4'd15 - bit_idx[3:0]] : 1'b0;
  end

  // Pin monitor: logs CS_n/SCLK activity and pushes by absolute cycle.
  int          cs_fall_cyc[$];
  int          sclk_fall_cyc[$];
  int          push_cyc[$];
  logic [15:0] push_din[$];
  int          cs_low_n = 0;
  int          sclk_low_n = 0;
  logic        mon_cs = 1'b1;
  logic        mon_sclk = 1'b1;

  always @(negedge Clk) begin
    if (!CS_n) begin
      cs_low_n++;
      if (mon_cs) cs_fall_cyc.push_back(cyc);
    end
    if (!SCLK) begin
      sclk_low_n++;
      if (mon_sclk) sclk_fall_cyc.push_back(cyc);
    end
    if (Fifo_Push) begin
      push_cyc.push_back(cyc);
      push_din.push_back(Fifo_Din);
    end
    mon_cs   = CS_n;
    mon_sclk = SCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    if (t0 + k > cyc) step(t0 + k - cyc);
  endtask

  task automatic do_reset();
    Enable  = 1'b0;
    Ovf_Clr = 1'b0;
    Rst     = 1'b1;
    step(2);
    Rst = 1'b0;
    step(1);
  endtask

  // Called 1 time unit after an edge: the current cycle becomes cycle 0.
  task automatic start_run();
    Enable = 1'b1;
    t0     = cyc;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [3:0]  pf;
    logic        exp_push;
    logic        exp_ovf;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bcs, bsf, bpush, bcl, bsl;

    vecs[0] = '{16'h0A5C, 4'h3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h8123, 4'hF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0FFF, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'hF000, 4'h0, 1'b0, 1'b1, 1'b1};

    // Reset state.
    do_reset();
    chk("rst_cs_n", CS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_push", Fifo_Push, 0);
    chk("rst_din", Fifo_Din, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_ferr", Frame_Err, 0);

    // Single-frame vectors.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      Push_Flag = vecs[i].pf;
      adc_word  = vecs[i].word;
      adc_inc   = 1'b0;
      bcs   = cs_fall_cyc.size();
      bsf   = sclk_fall_cyc.size();
      bpush = push_cyc.size();
      bcl   = cs_low_n;
      bsl   = sclk_low_n;
      start_run();
      wait_until(1);
      chk("cs_low_c1", CS_n, 0);
      wait_until(68);
      Enable = 1'b0;
      chk("cs_falls", cs_fall_cyc.size() - bcs, 1);
      if (cs_fall_cyc.size() > bcs) chk("cs_fall_cyc", cs_fall_cyc[bcs] - t0, 1);
      chk("cs_low_cycles", cs_low_n - bcl, 66);
      chk("sclk_falls", sclk_fall_cyc.size() - bsf, 16);
      if (sclk_fall_cyc.size() > bsf) chk("sclk_first_fall", sclk_fall_cyc[bsf] - t0, 3);
      chk("sclk_low_cycles", sclk_low_n - bsl, 32);
      chk("push_count", push_cyc.size() - bpush, {31'd0, vecs[i].exp_push});
      if (push_cyc.size() > bpush) begin
        chk("push_cyc", push_cyc[bpush] - t0, 67);
        chk("push_din", push_din[bpush], vecs[i].word);
      end
      chk("din_hold", Fifo_Din, vecs[i].word);
      chk("overflow", Overflow, vecs[i].exp_ovf);
      chk("frame_err", Frame_Err, vecs[i].exp_ferr);
      chk("busy_quiet", Busy, 1);
      wait_until(72);
      chk("busy_idle", Busy, 0);
    end

    // Ovf_Clr clears both sticky flags left by the last vector.
    Ovf_Clr = 1'b1;
    step(1);
    Ovf_Clr = 1'b0;
    chk("clr_ovf", Overflow, 0);
    chk("clr_ferr", Frame_Err, 0);

    // Periodic run: five frames, 80 cycles apart, incrementing data.
    do_reset();
    Push_Flag = 4'h7;
    adc_word  = 16'h0100;
    adc_inc   = 1'b1;
    inc_base  = m_frames;
    bpush     = push_cyc.size();
    start_run();
    wait_until(390);
    Enable = 1'b0;
    wait_until(480);
    chk("periodic_count", push_cyc.size() - bpush, 5);
    for (int k = 0; k < 5; k++) begin
      if (push_cyc.size() > bpush + k) begin
        chk("periodic_cyc", push_cyc[bpush+k] - t0, 67 + 80 * k);
        chk("periodic_din", push_din[bpush+k], 16'h0100 + 16'(k));
      end
    end
    adc_inc = 1'b0;

    // FIFO full: sticky overflow, clear, and set winning over clear.
    do_reset();
    Push_Flag = 4'h0;
    adc_word  = 16'h0123;
    bpush     = push_cyc.size();
    start_run();
    wait_until(68);
    chk("full_no_push", push_cyc.size() - bpush, 0);
    chk("full_ovf", Overflow, 1);
    Push_Flag = 4'h5;
    wait_until(148);
    chk("full_next_push", push_cyc.size() - bpush, 1);
    if (push_cyc.size() > bpush) chk("full_next_cyc", push_cyc[bpush] - t0, 147);
    chk("ovf_sticky", Overflow, 1);
    wait_until(150);
    Ovf_Clr = 1'b1;
    wait_until(151);
    Ovf_Clr = 1'b0;
    chk("ovf_cleared", Overflow, 0);
    Push_Flag = 4'h0;
    wait_until(227);
    Ovf_Clr = 1'b1;
    wait_until(228);
    Ovf_Clr = 1'b0;
    Enable  = 1'b0;
    chk("ovf_set_wins", Overflow, 1);
    chk("ovf_ferr_clean", Frame_Err, 0);
    Push_Flag = 4'hF;

    // Enable drops mid-frame: frame completes, nothing follows.
    do_reset();
    adc_word = 16'h0555;
    bpush    = push_cyc.size();
    bcs      = cs_fall_cyc.size();
    start_run();
    wait_until(30);
    Enable = 1'b0;
    wait_until(200);
    chk("drop_push_count", push_cyc.size() - bpush, 1);
    if (push_cyc.size() > bpush) begin
      chk("drop_push_cyc", push_cyc[bpush] - t0, 67);
      chk("drop_push_din", push_din[bpush], 16'h0555);
    end
    chk("drop_cs_falls", cs_fall_cyc.size() - bcs, 1);
    chk("drop_cs_idle", CS_n, 1);
    chk("drop_busy", Busy, 0);

    // Reset mid-frame, Enable held: clean restart at the next tick.
    do_reset();
    adc_word = 16'h0C3A;
    bpush    = push_cyc.size();
    start_run();
    wait_until(40);
    Rst = 1'b1;
    wait_until(41);
    chk("rstmid_cs_n", CS_n, 1);
    chk("rstmid_sclk", SCLK, 1);
    chk("rstmid_busy", Busy, 0);
    Rst = 1'b0;
    bcs = cs_fall_cyc.size();
    chk("rstmid_no_push", push_cyc.size() - bpush, 0);
    wait_until(115);
    Enable = 1'b0;
    chk("rstmid_push_count", push_cyc.size() - bpush, 1);
    if (push_cyc.size() > bpush) begin
      chk("rstmid_push_cyc", push_cyc[bpush] - t0, 108);
      chk("rstmid_push_din", push_din[bpush], 16'h0C3A);
    end
    if (cs_fall_cyc.size() > bcs) chk("rstmid_cs_fall", cs_fall_cyc[bcs] - t0, 42);
    else chk("rstmid_cs_fall_seen", cs_fall_cyc.size() - bcs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_ad7476_capture.md
# adc_ad7476_capture

Serial front end for the AD7476 12-bit ADC, sitting directly upstream of the 512x16 sample FIFO. It paces conversions from a programmable sample timer. For each conversion it drives CS_n and SCLK, shifts in the 16-bit SDATA frame, and pushes the word into the FIFO write port. When the FIFO is full, the sample is dropped and a sticky overflow flag is set.

## Interface
- `SCLK_DIV`, default 2: SCLK half-period in Clk cycles (≥1).
- `CS_QUIET`, default 4: minimum CS_n-high cycles after a frame (≥1).
- `SAMPLE_PERIOD`, default 80: Clk cycles between conversion starts. Must be ≥ 34·SCLK_DIV + 1 + CS_QUIET.
- `Clk`  in  1  system clock. One clock; all logic runs on it.
- `Rst`  in  1  synchronous, active-high reset.
- `Enable`  in  1  level; runs the sample timer.
- `Ovf_Clr`  in  1  pulse; clears Overflow and Frame_Err.
- `SDATA`  in  1  ADC serial data, already synchronised by the pad ring.
- `Push_Flag`  in  4  FIFO PUSH_FLAG; value 4'h0 = full.
- `CS_n`  out  1  ADC chip select. Reset value 1.
- `SCLK`  out  1  ADC serial clock, idles high. Reset value 1.
- `Fifo_Push`  out  1  one-cycle FIFO PUSH strobe. Reset value 0.
- `Fifo_Din`  out  16  FIFO DIN; valid while Fifo_Push=1. Reset value 0.
- `Busy`  out  1  FSM not in IDLE. Reset value 0.
- `Overflow`  out  1  sticky; a sample was dropped. Reset value 0.
- `Frame_Err`  out  1  sticky; leading nibble of a frame was nonzero. Reset value 0.

## Operation
- **Sample timer**
  - Counter is held at 0 while Enable=0.
  - While Enable=1 it counts 0..SAMPLE_PERIOD-1 and wraps.
  - `tick` = Enable & (counter==0).
- **FSM states:** IDLE, SETUP, SHIFT, DONE, QUIET.
- **IDLE:** on tick, go to SETUP. A tick arriving in any other state is ignored.
- **SETUP:** CS_n=0, SCLK=1 for SCLK_DIV cycles, then go to SHIFT.
- **SHIFT:** 16 bits. Each bit is SCLK=0 for SCLK_DIV cycles, then SCLK=1 for SCLK_DIV cycles.
  - SDATA is sampled into a 16-bit shift register, MSB first, on the last cycle of each low phase (the cycle whose edge drives SCLK high).
  - A 4-bit bit counter counts 15→0. After bit 0's high phase, go to DONE.
- **DONE (1 cycle):** CS_n=1, Fifo_Din = shift register.
  - If Push_Flag≠4'h0: Fifo_Push=1.
  - Else: Fifo_Push=0 and Overflow←1.
  - If shift[15:12]≠0: Frame_Err←1. The word is still pushed if there is room.
  - Go to QUIET.
- **QUIET:** CS_n=1 for CS_QUIET cycles, then go to IDLE.
- **Enable falling mid-frame:** the current frame completes, including its push. No new frame starts.
- **Rst mid-frame:** on the next edge, CS_n=1 and SCLK=1, FSM goes to IDLE, counters and shift register clear, and no push is issued.
- **Ovf_Clr coinciding with a new overflow or error event:** the set wins.
- Fifo_Din holds its last value outside DONE.

## Timing
- Enable rises, with the counter at 0, in cycle 0. SETUP is registered at the end of cycle 0, so CS_n falls in cycle 1.
- Frame length from CS_n low to DONE = SCLK_DIV + 32·SCLK_DIV cycles.
- With the defaults:
  - CS_n low cycles 1–66.
  - SCLK first falls in cycle 3.
  - The 16th sample is taken in cycle 64.
  - DONE and Fifo_Push in cycle 67.
  - QUIET cycles 68–71.
  - IDLE from cycle 72.
  - Next CS_n low in cycle 81.
- SCLK and CS_n are registered outputs with no combinational path from inputs.
- Push_Flag is sampled in the DONE cycle only. The FIFO registers the push on the same edge.

## Structure
- Package `adc_ad7476_pkg`:
  - FSM state enum.
  - `FIFO_FULL_FLAG` = 4'h0.
  - `ADC_FRAME_BITS` = 16.
- Sub-module `adc_sample_timer`: the period counter and tick generation.
- The FSM, SCLK phase counter, bit counter and shift register live in the top module.

## Test plan
- **Basic frame.** Defaults, Enable=1, ADC model returns 16'h0A5C. Expect:
  - CS_n low cycles 1–66.
  - 16 SCLK low pulses of 2 cycles each.
  - Fifo_Push in cycle 67 with Fifo_Din=16'h0A5C.
  - Overflow=0 and Frame_Err=0.
- **Periodic run.** Enable held for 5 periods, model returns an incrementing count. Expect 5 pushes spaced exactly 80 cycles apart, carrying the consecutive values.
- **FIFO full.** Push_Flag=4'h0 during DONE. Expect:
  - Fifo_Push=0 and Overflow=1, which remains set across later good frames.
  - Ovf_Clr clears it the following cycle.
- **Frame error.** Model returns 16'h8123. Expect 16'h8123 pushed and Frame_Err=1.
- **Enable drop mid-frame.** Enable=0 in cycle 30. Expect the frame to complete with its push in cycle 67, followed by no further CS_n activity.
- **Reset mid-frame.** Rst in cycle 40. Expect:
  - CS_n=1, SCLK=1 and Busy=0 in cycle 41.
  - No push.
  - With Enable still high after Rst releases, a clean frame starts at the next tick.
